// File: rtl/multicycle_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer_pkg : RV32I opcodes, FSM states, trap and WB codes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package multicycle_sequencer_pkg;

  localparam logic [6:0] OPC_R       = 7'b0110011;
  localparam logic [6:0] OPC_I_ARITH = 7'b0010011;
  localparam logic [6:0] OPC_I_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_S       = 7'b0100011;
  localparam logic [6:0] OPC_B       = 7'b1100011;
  localparam logic [6:0] OPC_U_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_U_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_J       = 7'b1101111;
  localparam logic [6:0] OPC_I_JUMP  = 7'b1100111;
  localparam logic [6:0] OPC_I_FENCE = 7'b0001111;
  localparam logic [6:0] OPC_I_SYS   = 7'b1110011;

  // Bit positions inside the one-hot class vector
  localparam int NUM_CLASSES = 11;
  localparam int CLS_R       = 0;
  localparam int CLS_I_ARITH = 1;
  localparam int CLS_I_LOAD  = 2;
  localparam int CLS_S       = 3;
  localparam int CLS_B       = 4;
  localparam int CLS_U_LUI   = 5;
  localparam int CLS_U_AUIPC = 6;
  localparam int CLS_J       = 7;
  localparam int CLS_I_JUMP  = 8;
  localparam int CLS_I_FENCE = 9;
  localparam int CLS_I_SYS   = 10;

  typedef logic [NUM_CLASSES-1:0] opc_class_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;
  localparam logic [2:0] ST_TRAP   = 3'd7;

  localparam logic [1:0] CAUSE_NONE          = 2'd0;
  localparam logic [1:0] CAUSE_FETCH_TIMEOUT = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL       = 2'd2;
  localparam logic [1:0] CAUSE_DATA_TIMEOUT  = 2'd3;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

endpackage

`default_nettype wire

// File: rtl/multicycle_sequencer_if.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer_if : sequencer control/status bundle (slave = FSM side)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface multicycle_sequencer_if #(
  parameter int INSTRET_W = 32
);

  logic [6:0]           i_opcode;
  logic                 i_mem_ready;
  logic                 i_branch_taken;
  logic                 i_stall;
  logic [2:0]           o_state;
  logic                 o_mem_req;
  logic                 o_mem_we;
  logic                 o_ir_we;
  logic                 o_pc_we;
  logic                 o_pc_sel;
  logic                 o_rf_we;
  logic [1:0]           o_wb_sel;
  logic                 o_instret;
  logic [INSTRET_W-1:0] o_instret_cnt;
  logic                 o_halt;
  logic                 o_trap;
  logic [1:0]           o_trap_cause;

  modport slave (
    input  i_opcode, i_mem_ready, i_branch_taken, i_stall,
    output o_state, o_mem_req, o_mem_we, o_ir_we, o_pc_we, o_pc_sel, o_rf_we,
           o_wb_sel, o_instret, o_instret_cnt, o_halt, o_trap, o_trap_cause
  );

  modport master (
    output i_opcode, i_mem_ready, i_branch_taken, i_stall,
    input  o_state, o_mem_req, o_mem_we, o_ir_we, o_pc_we, o_pc_sel, o_rf_we,
           o_wb_sel, o_instret, o_instret_cnt, o_halt, o_trap, o_trap_cause
  );

endinterface

`default_nettype wire

// File: rtl/multicycle_sequencer_opcode_class.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer_opcode_class : opcode -> one-hot class + illegal flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_sequencer_opcode_class
  import multicycle_sequencer_pkg::*;
(
  input  logic [6:0] opcode_i,
  output opc_class_t class_o,
  output logic       illegal_o
);

  always_comb begin
    class_o = '0;
    case (opcode_i)
      OPC_R:       class_o[CLS_R]       = 1'b1;
      OPC_I_ARITH: class_o[CLS_I_ARITH] = 1'b1;
      OPC_I_LOAD:  class_o[CLS_I_LOAD]  = 1'b1;
      OPC_S:       class_o[CLS_S]       = 1'b1;
      OPC_B:       class_o[CLS_B]       = 1'b1;
      OPC_U_LUI:   class_o[CLS_U_LUI]   = 1'b1;
      OPC_U_AUIPC: class_o[CLS_U_AUIPC] = 1'b1;
      OPC_J:       class_o[CLS_J]       = 1'b1;
      OPC_I_JUMP:  class_o[CLS_I_JUMP]  = 1'b1;
      OPC_I_FENCE: class_o[CLS_I_FENCE] = 1'b1;
      OPC_I_SYS:   class_o[CLS_I_SYS]   = 1'b1;
      default:     class_o = '0;
    endcase
  end

  assign illegal_o = ~|class_o;

endmodule

`default_nettype wire

// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer : fetch/decode/exec/mem/wb control FSM with traps
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int INSTRET_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  multicycle_sequencer_if.slave bus
);

  localparam logic [TIMEOUT_W-1:0] WAIT_MAX = '1;

  logic [2:0]           state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic [1:0]           cause_q, cause_d;
  logic [INSTRET_W-1:0] instret_cnt_q;

  opc_class_t           w_class;
  logic                 w_illegal;
  logic [TIMEOUT_W-1:0] w_wait_inc;
  logic                 w_timeout;
  logic                 w_is_mem, w_is_pc_only, w_is_wb, w_is_jump;

  logic                 w_mem_req, w_mem_we, w_ir_we, w_pc_we, w_pc_sel, w_rf_we;
  logic [1:0]           w_wb_sel;
  logic                 w_retire;

  multicycle_sequencer_opcode_class u_opcode_class (
    .opcode_i  (bus.i_opcode),
    .class_o   (w_class),
    .illegal_o (w_illegal)
  );

  assign w_is_mem     = w_class[CLS_I_LOAD] | w_class[CLS_S];
  assign w_is_pc_only = w_class[CLS_B] | w_class[CLS_I_FENCE];
  assign w_is_jump    = w_class[CLS_J] | w_class[CLS_I_JUMP];
  assign w_is_wb      = w_class[CLS_R] | w_class[CLS_I_ARITH] | w_class[CLS_U_LUI]
                      | w_class[CLS_U_AUIPC] | w_is_jump;

  // Timeout fires on the cycle whose increment would reach the all-ones value
  assign w_wait_inc = wait_q + TIMEOUT_W'(1);
  assign w_timeout  = (w_wait_inc == WAIT_MAX);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      wait_q        <= '0;
      cause_q       <= CAUSE_NONE;
      instret_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      if (w_retire) begin
        instret_cnt_q <= instret_cnt_q + INSTRET_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.i_mem_ready) begin
          state_d = ST_DECODE;
        end else if (w_timeout) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_FETCH_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (!bus.i_stall) begin
          if (w_illegal) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (!bus.i_stall) begin
          if (w_is_mem) begin
            state_d = ST_MEM;
          end else if (w_is_pc_only) begin
            state_d = ST_FETCH;
          end else if (w_class[CLS_I_SYS]) begin
            state_d = ST_HALT;
          end else if (w_is_wb) begin
            state_d = ST_WB;
          end else begin
            // Opcode changed after DECODE; treat as illegal rather than guess
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        end
      end
      ST_MEM: begin
        if (bus.i_mem_ready) begin
          state_d = w_class[CLS_S] ? ST_FETCH : ST_WB;
        end else if (w_timeout) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DATA_TIMEOUT;
        end
      end
      ST_WB: begin
        if (!bus.i_stall) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == ST_FETCH || state_q == ST_MEM) && wait_q != WAIT_MAX) begin
      wait_d = w_wait_inc;
    end
  end

  always_comb begin
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    w_ir_we   = 1'b0;
    w_pc_we   = 1'b0;
    w_pc_sel  = 1'b0;
    w_rf_we   = 1'b0;
    w_wb_sel  = WB_SEL_ALU;
    w_retire  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        w_mem_req = 1'b1;
        w_ir_we   = bus.i_mem_ready;
      end
      ST_EXEC: begin
        w_pc_sel = w_class[CLS_B] & bus.i_branch_taken;
        if (!bus.i_stall && w_is_pc_only) begin
          w_pc_we  = 1'b1;
          w_retire = 1'b1;
        end
      end
      ST_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = w_class[CLS_S];
        if (bus.i_mem_ready && w_class[CLS_S]) begin
          w_pc_we  = 1'b1;
          w_retire = 1'b1;
        end
      end
      ST_WB: begin
        w_wb_sel = w_class[CLS_I_LOAD] ? WB_SEL_MEM :
                   w_is_jump           ? WB_SEL_PC4 : WB_SEL_ALU;
        w_pc_sel = w_is_jump;
        if (!bus.i_stall) begin
          w_rf_we  = 1'b1;
          w_pc_we  = 1'b1;
          w_retire = 1'b1;
        end
      end
      default: w_mem_req = 1'b0;
    endcase
  end

  assign bus.o_state       = state_q;
  assign bus.o_mem_req     = w_mem_req;
  assign bus.o_mem_we      = w_mem_we;
  assign bus.o_ir_we       = w_ir_we;
  assign bus.o_pc_we       = w_pc_we;
  assign bus.o_pc_sel      = w_pc_sel;
  assign bus.o_rf_we       = w_rf_we;
  assign bus.o_wb_sel      = w_wb_sel;
  assign bus.o_instret     = w_retire;
  assign bus.o_instret_cnt = instret_cnt_q;
  assign bus.o_halt        = (state_q == ST_HALT);
  assign bus.o_trap        = (state_q == ST_TRAP);
  assign bus.o_trap_cause  = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer : directed vectors, per-cycle expected-output scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3;
  localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_TRAP = 3'd7;

  // Strobe bundle order: {mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we, instret}
  localparam logic [6:0] SB_NONE      = 7'b0000000;
  localparam logic [6:0] SB_FETCH     = 7'b1000000;
  localparam logic [6:0] SB_FETCH_RDY = 7'b1010000;
  localparam logic [6:0] SB_PC4_RET   = 7'b0001001;
  localparam logic [6:0] SB_TGT_RET   = 7'b0001101;
  localparam logic [6:0] SB_WB        = 7'b0001011;
  localparam logic [6:0] SB_WB_JUMP   = 7'b0001111;
  localparam logic [6:0] SB_LD_MEM    = 7'b1000000;
  localparam logic [6:0] SB_ST_MEM    = 7'b1100000;
  localparam logic [6:0] SB_ST_DONE   = 7'b1101001;

  localparam logic [6:0] OP_ADD = 7'h33, OP_LW = 7'h03, OP_SW = 7'h23, OP_BEQ = 7'h63;
  localparam logic [6:0] OP_LUI = 7'h37, OP_JAL = 7'h6F, OP_FENCE = 7'h0F;
  localparam logic [6:0] OP_ECALL = 7'h73, OP_BAD = 7'h7F;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, ir, pcwe, pcsel, rf;
    logic [1:0] wbs;
    logic       ret;
    logic [3:0] cnt;
    logic       halt, trap;
    logic [1:0] cause;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_sequencer_if #(.INSTRET_W(4)) bus ();

  multicycle_sequencer #(.TIMEOUT_W(3), .INSTRET_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  exp_t       exp_q[$];
  string      name_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [3:0] ecnt  = 4'd0;

  function automatic exp_t x(input logic [2:0] st, input logic [6:0] sb, input logic [1:0] wbs,
                             input logic [3:0] cnt, input logic [1:0] cause);
    exp_t e;
    e.st = st;
    {e.req, e.we, e.ir, e.pcwe, e.pcsel, e.rf, e.ret} = sb;
    e.wbs   = wbs;
    e.cnt   = cnt;
    e.halt  = (st == S_HALT);
    e.trap  = (st == S_TRAP);
    e.cause = cause;
    return e;
  endfunction

  // Drive one cycle's inputs and queue what the DUT must show during that cycle
  task automatic step(input string nm, input logic rn, input logic [6:0] op, input logic rdy,
                      input logic tk, input logic stl, input exp_t e);
    @(posedge clk);
    #1;
    rst_n              = rn;
    bus.i_opcode       = op;
    bus.i_mem_ready    = rdy;
    bus.i_branch_taken = tk;
    bus.i_stall        = stl;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_reset(input exp_t cur);
    step("rst_assert", 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, cur);
    step("rst_idle", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, x(S_IDLE, SB_NONE, 2'd0, 4'd0, 2'd0));
    ecnt = 4'd0;
  endtask

  task automatic front(input string nm, input logic [6:0] op);
    step({nm, "_fetch"}, 1'b1, op, 1'b1, 1'b0, 1'b0, x(S_FETCH, SB_FETCH_RDY, 2'd0, ecnt, 2'd0));
    step({nm, "_dec"}, 1'b1, op, 1'b0, 1'b0, 1'b0, x(S_DEC, SB_NONE, 2'd0, ecnt, 2'd0));
  endtask

  task automatic run_alu(input string nm, input logic [6:0] op, input logic jump);
    front(nm, op);
    step({nm, "_exec"}, 1'b1, op, 1'b0, 1'b0, 1'b0, x(S_EXEC, SB_NONE, 2'd0, ecnt, 2'd0));
    step({nm, "_wb"}, 1'b1, op, 1'b0, 1'b0, 1'b0,
         x(S_WB, jump ? SB_WB_JUMP : SB_WB, jump ? 2'd2 : 2'd0, ecnt, 2'd0));
    ecnt++;
  endtask

  initial begin : monitor
    exp_t  e;
    exp_t  a;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = {bus.o_state, bus.o_mem_req, bus.o_mem_we, bus.o_ir_we, bus.o_pc_we, bus.o_pc_sel,
             bus.o_rf_we, bus.o_wb_sel, bus.o_instret, bus.o_instret_cnt, bus.o_halt,
             bus.o_trap, bus.o_trap_cause};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s @%0t: got %h want %h (state %0d/%0d cnt %0d/%0d cause %0d/%0d)",
                   n, $time, a, e, a.st, e.st, a.cnt, e.cnt, a.cause, e.cause);
        end
      end
    end
  end

  initial begin : stimulus
    bus.i_opcode       = OP_ADD;
    bus.i_mem_ready    = 1'b0;
    bus.i_branch_taken = 1'b0;
    bus.i_stall        = 1'b0;

    do_reset(x(S_IDLE, SB_NONE, 2'd0, 4'd0, 2'd0));

    run_alu("add", OP_ADD, 1'b0);
    run_alu("lui", OP_LUI, 1'b0);
    run_alu("jal", OP_JAL, 1'b1);

    front("lw", OP_LW);
    step("lw_exec", 1'b1, OP_LW, 1'b0, 1'b0, 1'b0, x(S_EXEC, SB_NONE, 2'd0, ecnt, 2'd0));
    for (int i = 0; i < 3; i++)
      step("lw_mem_wait", 1'b1, OP_LW, 1'b0, 1'b0, 1'b0, x(S_MEM, SB_LD_MEM, 2'd0, ecnt, 2'd0));
    step("lw_mem_done", 1'b1, OP_LW, 1'b1, 1'b0, 1'b0, x(S_MEM, SB_LD_MEM, 2'd0, ecnt, 2'd0));
    step("lw_wb", 1'b1, OP_LW, 1'b0, 1'b0, 1'b0, x(S_WB, SB_WB, 2'd1, ecnt, 2'd0));
    ecnt++;

    front("sw", OP_SW);
    step("sw_exec", 1'b1, OP_SW, 1'b0, 1'b0, 1'b0, x(S_EXEC, SB_NONE, 2'd0, ecnt, 2'd0));
    step("sw_mem_wait", 1'b1, OP_SW, 1'b0, 1'b0, 1'b0, x(S_MEM, SB_ST_MEM, 2'd0, ecnt, 2'd0));
    step("sw_mem_done", 1'b1, OP_SW, 1'b1, 1'b0, 1'b0, x(S_MEM, SB_ST_DONE, 2'd0, ecnt, 2'd0));
    ecnt++;

    front("beq_t", OP_BEQ);
    step("beq_t_exec", 1'b1, OP_BEQ, 1'b0, 1'b1, 1'b0, x(S_EXEC, SB_TGT_RET, 2'd0, ecnt, 2'd0));
    ecnt++;
    front("beq_nt", OP_BEQ);
    step("beq_nt_exec", 1'b1, OP_BEQ, 1'b0, 1'b0, 1'b0, x(S_EXEC, SB_PC4_RET, 2'd0, ecnt, 2'd0));
    ecnt++;
    front("fence", OP_FENCE);
    step("fence_exec", 1'b1, OP_FENCE, 1'b0, 1'b1, 1'b0, x(S_EXEC, SB_PC4_RET, 2'd0, ecnt, 2'd0));
    ecnt++;

    // Stall ignored in FETCH, honoured in DECODE, EXEC and WB
    step("stl_fetch_wait", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, x(S_FETCH, SB_FETCH, 2'd0, ecnt, 2'd0));
    step("stl_fetch_done", 1'b1, OP_ADD, 1'b1, 1'b0, 1'b1, x(S_FETCH, SB_FETCH_RDY, 2'd0, ecnt, 2'd0));
    step("stl_dec", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, x(S_DEC, SB_NONE, 2'd0, ecnt, 2'd0));
    step("stl_dec_go", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, x(S_DEC, SB_NONE, 2'd0, ecnt, 2'd0));
    for (int i = 0; i < 5; i++)
      step("stl_exec", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, x(S_EXEC, SB_NONE, 2'd0, ecnt, 2'd0));
    step("stl_exec_go", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, x(S_EXEC, SB_NONE, 2'd0, ecnt, 2'd0));
    step("stl_wb", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, x(S_WB, SB_NONE, 2'd0, ecnt, 2'd0));
    step("stl_wb_go", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, x(S_WB, SB_WB, 2'd0, ecnt, 2'd0));
    ecnt++;

    for (int i = 0; i < 7; i++)
      step("fto_wait", 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, x(S_FETCH, SB_FETCH, 2'd0, ecnt, 2'd0));
    for (int i = 0; i < 3; i++)
      step("fto_trap", 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, x(S_TRAP, SB_NONE, 2'd0, ecnt, 2'd1));
    do_reset(x(S_TRAP, SB_NONE, 2'd0, ecnt, 2'd1));

    front("ill", OP_BAD);
    for (int i = 0; i < 20; i++)
      step("ill_trap", 1'b1, OP_BAD, 1'b1, 1'b0, 1'b0, x(S_TRAP, SB_NONE, 2'd0, ecnt, 2'd2));
    do_reset(x(S_TRAP, SB_NONE, 2'd0, ecnt, 2'd2));

    front("dto", OP_LW);
    step("dto_exec", 1'b1, OP_LW, 1'b0, 1'b0, 1'b0, x(S_EXEC, SB_NONE, 2'd0, ecnt, 2'd0));
    for (int i = 0; i < 7; i++)
      step("dto_wait", 1'b1, OP_LW, 1'b0, 1'b0, 1'b1, x(S_MEM, SB_LD_MEM, 2'd0, ecnt, 2'd0));
    for (int i = 0; i < 2; i++)
      step("dto_trap", 1'b1, OP_LW, 1'b1, 1'b0, 1'b0, x(S_TRAP, SB_NONE, 2'd0, ecnt, 2'd3));
    do_reset(x(S_TRAP, SB_NONE, 2'd0, ecnt, 2'd3));

    for (int i = 0; i < 17; i++)
      run_alu("wrap_add", OP_ADD, 1'b0);
    front("ecall", OP_ECALL);
    step("ecall_exec", 1'b1, OP_ECALL, 1'b0, 1'b0, 1'b0, x(S_EXEC, SB_NONE, 2'd0, ecnt, 2'd0));
    for (int i = 0; i < 4; i++)
      step("halt_hold", 1'b1, OP_ECALL, 1'b1, 1'b0, 1'b0, x(S_HALT, SB_NONE, 2'd0, 4'd1, 2'd0));

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control FSM for the non-pipelined flintRV core variant. It sequences fetch, decode, execute, memory and writeback phases over a single shared memory port. It uses the opcode classification of the existing RV32I opcode defines. It drives the per-phase register write enables and the PC, writeback and memory strobes, and counts retired instructions. It also traps on illegal opcodes or memory timeouts.

Parameters:
TIMEOUT_W, 8, width of memory-wait counter; timeout fires when counter reaches 2^TIMEOUT_W-1
INSTRET_W, 32, width of retired-instruction counter

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  synchronous active-low reset
i_opcode  input  7  opcode field of instruction register (stable from DECODE onward)
i_mem_ready  input  1  memory completes current request this cycle
i_branch_taken  input  1  ALU compare result, sampled in EXEC for B-type
i_stall  input  1  external freeze request
o_state  output  3  current state encoding
o_mem_req  output  1  memory request valid
o_mem_we  output  1  memory write (store), qualified by o_mem_req
o_ir_we  output  1  load instruction register
o_pc_we  output  1  update PC
o_pc_sel  output  1  0 = PC+4, 1 = branch/jump target
o_rf_we  output  1  register file write
o_wb_sel  output  2  0 = ALU, 1 = memory data, 2 = PC+4
o_instret  output  1  one-cycle pulse per retired instruction
o_instret_cnt  output  INSTRET_W  retired-instruction count
o_halt  output  1  sticky, I_SYS reached
o_trap  output  1  sticky trap flag
o_trap_cause  output  2  0 none, 1 fetch timeout, 2 illegal opcode, 3 data timeout

Behaviour:
- Reset: i_rst_n low at an edge sets state IDLE. All outputs and counters are 0. Reset mid-request drops o_mem_req at that edge.
- State encoding: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, HALT 6, TRAP 7.
- IDLE: always moves to FETCH on the next edge.
- FETCH:
  - Asserts o_mem_req with o_mem_we = 0.
  - If i_mem_ready: o_ir_we = 1 that cycle, next state DECODE.
  - Otherwise the wait counter increments. At saturation go to TRAP with cause 1.
- DECODE: one cycle. An opcode outside the 11 RV32I classes goes to TRAP with cause 2. Any other opcode goes to EXEC.
- EXEC: one cycle. Next state by class:
  - I_LOAD and S go to MEM.
  - R, I_ARITH, U_LUI, U_AUIPC, J and I_JUMP go to WB.
  - B: o_pc_we = 1 and o_pc_sel = i_branch_taken; retire; go to FETCH.
  - I_FENCE: o_pc_we = 1 and o_pc_sel = 0; retire; go to FETCH.
  - I_SYS goes to HALT with no retire.
- MEM:
  - Asserts o_mem_req, with o_mem_we = 1 for S.
  - On i_mem_ready: S sets o_pc_we = 1 and o_pc_sel = 0, retires and goes to FETCH. I_LOAD goes to WB.
  - Timeout goes to TRAP with cause 3.
- WB:
  - o_rf_we = 1.
  - o_wb_sel = 1 for I_LOAD, 2 for J/I_JUMP, 0 otherwise.
  - o_pc_we = 1, with o_pc_sel = 1 for J/I_JUMP and 0 otherwise.
  - Retire; go to FETCH.
- Retire: o_instret pulses in the retiring cycle. o_instret_cnt increments at the same edge and wraps modulo 2^INSTRET_W.
- Wait counter: cleared on entry to FETCH and to MEM. Saturates and never wraps.
- i_stall in DECODE, EXEC or WB: state holds; o_rf_we, o_pc_we, o_ir_we and o_instret are forced to 0.
- i_stall in FETCH or MEM is ignored, so an outstanding request is never dropped.
- HALT and TRAP: all strobes are 0; o_halt or o_trap (with cause) stays held until reset. i_mem_ready is ignored there.
- Strobes are Moore-style (decoded from state and opcode class) except o_ir_we and the MEM-completion strobes, which also depend on i_mem_ready.
- No combinational path from i_mem_ready to o_mem_req.

Decomposition:
- Shared header: the existing opcode defines, plus new state encodings, trap cause codes and WB_SEL codes.
- One combinational sub-module, opcode_class, maps i_opcode to a one-hot class vector plus an illegal flag.
- The FSM, wait counter and instret counter live in the top module.

Test Plan:
- R-type 0x33 with i_mem_ready = 1 in FETCH: states 1,2,3,5 then 1. o_rf_we and o_pc_we are 1 in WB with wb_sel 0. instret_cnt becomes 1 after 4 cycles.
- Load 0x03 with ready delayed 3 cycles in MEM: o_mem_req held for 4 cycles with o_mem_we = 0. WB then has wb_sel 1. Total is 8 cycles after the first FETCH.
- Branch 0x63 with i_branch_taken = 1 in EXEC: o_pc_sel = 1, o_pc_we = 1, back to FETCH after 3 cycles, no o_rf_we. Repeat with taken = 0: o_pc_sel = 0.
- Opcode 0x7F in DECODE: TRAP, o_trap = 1, cause 2, held for 20 cycles. A reset pulse clears it to IDLE.
- i_mem_ready held 0 with TIMEOUT_W = 3: TRAP cause 1 after 7 wait cycles. i_stall = 1 for 5 cycles in EXEC holds state 3 with all strobes 0.
- INSTRET_W = 4 with 17 consecutive ADDs: o_instret_cnt wraps to 1. An ECALL (0x73) afterwards sets o_halt, and the counter stays at 1.
